// File: rtl/msk_inv_pipe.sv
// Pipelined masked NOT over count lanes of d-share Boolean-masked bits.
// Optional share refresh happens at stage 0. Every output share comes straight from a register.

module msk_inv_lane #(
  parameter int D       = 2,
  parameter int REFRESH = 1,
  parameter int RWL     = 1
) (
  input  logic [D-1:0]   s,
  input  logic           inv,
  input  logic [RWL-1:0] r,
  output logic [D-1:0]   t
);
  generate
    if (REFRESH != 0 && D > 1) begin : g_ref
      // Share j>=1 takes r[j-1]. Share 0 absorbs every r bit, so the unmasked value is unchanged.
      always_comb begin
        t      = s;
        t[0]   = s[0] ^ inv ^ (^r);
        for (int j = 1; j < D; j++) t[j] = s[j] ^ r[j-1];
      end
    end else begin : g_pass
      // Randomness is not consumed in this mode. It is folded in as a constant 0 so the port stays referenced.
      always_comb begin
        t    = s;
        t[0] = s[0] ^ inv ^ (1'b0 & (^r));
      end
    end
  endgenerate
endmodule

module msk_inv_pipe #(
  parameter int d       = 2,
  parameter int count   = 1,
  parameter int LAT     = 2,
  parameter int REFRESH = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [count*d-1:0]                  in,
  input  logic [count-1:0]                    inv_mask,
  input  logic [count*((d>1)?d-1:1)-1:0]      rnd,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [count*d-1:0]                  out,
  output logic                                busy
);
  localparam int W   = count*d;
  localparam int RWL = (d > 1) ? d-1 : 1;

  logic [W-1:0] x;

  genvar i;
  generate
    for (i = 0; i < count; i++) begin : g_lane
      msk_inv_lane #(.D(d), .REFRESH(REFRESH), .RWL(RWL)) u_lane (
        .s   (in[i*d +: d]),
        .inv (inv_mask[i]),
        .r   (rnd[i*RWL +: RWL]),
        .t   (x[i*d +: d])
      );
    end
  endgenerate

  logic [LAT-1:0]        v_q, v_d;
  logic [LAT-1:0][W-1:0] r_q, r_d;
  logic [LAT-1:0]        adv, up_v;
  logic [LAT-1:0][W-1:0] up_r;
  logic                  all_v;

  always_comb begin
    up_v[0] = in_valid;
    up_r[0] = x;
    for (int k = 1; k < LAT; k++) begin
      up_v[k] = v_q[k-1];
      up_r[k] = r_q[k-1];
    end
    // A stage stalls only if it and every stage after it are full while out_ready is low.
    all_v = 1'b1;
    for (int k = LAT-1; k >= 0; k--) begin
      all_v  = all_v & v_q[k];
      adv[k] = out_ready | ~all_v;
    end
    v_d = v_q;
    r_d = r_q;
    for (int k = 0; k < LAT; k++) begin
      if (adv[k]) begin
        v_d[k] = up_v[k];
        if (up_v[k]) r_d[k] = up_r[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      r_q <= '0;
    end else begin
      v_q <= v_d;
      r_q <= r_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[LAT-1];
  assign out       = r_q[LAT-1];
  assign busy      = |v_q;
endmodule

// File: tb/tb_msk_inv_pipe.sv
// Bench for msk_inv_pipe: three configurations share one handshake.
// A scoreboard checks each configuration against a share-level reference model.
`timescale 1ns/1ps
module tb_msk_inv_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0] in_ab = '0, in_c = '0, inv_c = '0, rnd_c = '0;
  logic [1:0] inv_ab = '0, rnd_ab = '0;
  logic [3:0] out_a, out_b, out_c;
  logic       ir_a, ir_b, ir_c, ov_a, ov_b, ov_c, bz_a, bz_b, bz_c;

  int chk = 0, err = 0;
  logic [3:0] qa[$], qb[$], qc[$];
  logic [3:0] snap;

  msk_inv_pipe #(.d(2), .count(2), .LAT(2), .REFRESH(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a), .in(in_ab),
    .inv_mask(inv_ab), .rnd(rnd_ab), .out_valid(ov_a), .out_ready(out_ready),
    .out(out_a), .busy(bz_a));
  msk_inv_pipe #(.d(2), .count(2), .LAT(2), .REFRESH(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b), .in(in_ab),
    .inv_mask(inv_ab), .rnd(rnd_ab), .out_valid(ov_b), .out_ready(out_ready),
    .out(out_b), .busy(bz_b));
  msk_inv_pipe #(.d(1), .count(4), .LAT(1), .REFRESH(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_c), .in(in_c),
    .inv_mask(inv_c), .rnd(rnd_c), .out_valid(ov_c), .out_ready(out_ready),
    .out(out_c), .busy(bz_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Model of two 2-share lanes: refresh re-splits each lane with r[i]. Inversion lands on share 0.
  function automatic logic [3:0] model_ab(input logic [3:0] s, input logic [1:0] inv,
                                          input logic [1:0] r, input bit refresh);
    logic [3:0] o;
    o = s;
    for (int l = 0; l < 2; l++) begin
      o[2*l] = o[2*l] ^ inv[l];
      if (refresh) begin
        o[2*l]   = o[2*l]   ^ r[l];
        o[2*l+1] = o[2*l+1] ^ r[l];
      end
    end
    return o;
  endfunction

  // Scoreboard: pop on emit, push on accept. Both are sampled at the negedge ahead of the edge where they happen.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov_a && out_ready) begin
        if (qa.size() == 0) check("a_extra_beat", 1, 0); else check("a_out", out_a, qa.pop_front());
      end
      if (ov_b && out_ready) begin
        if (qb.size() == 0) check("b_extra_beat", 1, 0); else check("b_out", out_b, qb.pop_front());
      end
      if (ov_c && out_ready) begin
        if (qc.size() == 0) check("c_extra_beat", 1, 0); else check("c_out", out_c, qc.pop_front());
      end
      if (in_valid && ir_a) qa.push_back(model_ab(in_ab, inv_ab, rnd_ab, 1'b0));
      if (in_valid && ir_b) qb.push_back(model_ab(in_ab, inv_ab, rnd_ab, 1'b1));
      if (in_valid && ir_c) qc.push_back(in_c ^ inv_c);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data;
    in_ab  = 4'($urandom);
    inv_ab = 2'($urandom);
    rnd_ab = 2'($urandom);
    in_c   = 4'($urandom);
    inv_c  = 4'($urandom);
    rnd_c  = 4'($urandom);
  endtask

  initial begin
    #12;
    check("rst_out_a", out_a, 0); check("rst_ov_a", ov_a, 0);
    check("rst_busy_a", bz_a, 0); check("rst_in_ready_a", ir_a, 1);
    check("rst_out_c", out_c, 0); check("rst_ov_c", ov_c, 0);
    rst_n = 1'b1;
    tick;

    // Directed single beat for all three configurations
    in_valid = 1; in_ab = 4'b0110; inv_ab = 2'b01; rnd_ab = 2'b11;
    in_c = 4'b1010; inv_c = 4'b1100;
    tick;
    in_valid = 0;
    check("lat_a_cyc1_valid", ov_a, 0);
    check("lat_c_valid", ov_c, 1);
    check("c_d1_value", out_c, 4'b0110);
    tick;
    check("lat_a_cyc2_valid", ov_a, 1);
    check("a_norefresh_value", out_a, 4'b0111);
    check("b_refresh_value", out_b, 4'b1000);
    check("b_unmasked_xor", {^out_b[3:2], ^out_b[1:0]}, 2'b10);
    check("c_single_pulse", ov_c, 0);
    tick;
    check("a_single_pulse", ov_a, 0);
    check("a_busy_idle", bz_a, 0);

    // Eight back-to-back beats at full throughput
    for (int n = 0; n < 8; n++) begin
      in_valid = 1; rand_data;
      #1 check("stream_in_ready_a", ir_a, 1);
      check("stream_in_ready_c", ir_c, 1);
      tick;
    end
    in_valid = 0;
    repeat (3) tick;

    // Backpressure: only LAT beats fit while the output is held
    out_ready = 0;
    for (int n = 0; n < 5; n++) begin
      in_valid = 1; rand_data;
      tick;
    end
    check("bp_in_ready_a", ir_a, 0);
    check("bp_in_ready_c", ir_c, 0);
    check("bp_ov_a", ov_a, 1);
    snap = out_a;
    for (int n = 0; n < 3; n++) begin
      rand_data;
      tick;
      check("bp_out_a_stable", out_a, snap);
      check("bp_qa_depth", qa.size(), 2);
    end
    in_valid = 0; out_ready = 1;
    repeat (4) tick;
    check("bp_drained_a", qa.size(), 0);
    check("bp_drained_c", qc.size(), 0);

    // Asynchronous reset with the pipelines full
    out_ready = 0; in_valid = 1;
    for (int n = 0; n < 3; n++) begin rand_data; tick; end
    in_valid = 0;
    #3 rst_n = 0;
    #1;
    check("arst_ov_a", ov_a, 0); check("arst_out_a", out_a, 0);
    check("arst_busy_a", bz_a, 0); check("arst_busy_b", bz_b, 0);
    check("arst_ov_c", ov_c, 0); check("arst_out_c", out_c, 0);
    qa.delete(); qb.delete(); qc.delete();
    tick;
    rst_n = 1; out_ready = 1;
    #1 check("post_rst_in_ready", ir_a, 1);
    repeat (4) begin
      tick;
      check("post_rst_no_stale", ov_a | ov_b | ov_c, 0);
    end

    // Random traffic with random backpressure
    for (int n = 0; n < 300; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data;
      tick;
    end
    in_valid = 0; out_ready = 1;
    for (int n = 0; n < 20 && (qa.size() + qb.size() + qc.size()) != 0; n++) tick;
    check("final_drain", qa.size() + qb.size() + qc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
